// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative multiply/divide unit. One bit per cycle: shift-add for
//            multiply, restoring shift-subtract for divide. DATA_WIDTH cycles
//            in RUN, then a one-cycle DONE that updates hi/lo.
// Ports    : clk, reset (async, active-high)
//            start, op[1:0] (00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//            operand_a / operand_b : multiplicand/multiplier or dividend/divisor
//            busy, done, div_zero  : status; done/div_zero are one-cycle pulses
//            hi / lo               : product halves, or remainder / quotient
// Config   : `define MULT_DIV_DIVIDE_EN to include the divider datapath and
//            ops 10/11. Without it, divide requests are ignored and div_zero
//            is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_m;      // multiplicand or divisor magnitude
  logic [2*W-1:0]   r_p;      // {acc, multiplier} or {remainder, dividend/quotient}
  logic             r_neg_lo; // negate product / quotient at completion
  logic [W-1:0]     r_hi, r_lo;

  logic             w_op_ok, w_accept, w_last;
  logic             w_a_neg, w_b_neg;
  logic [W-1:0]     w_a_mag, w_b_mag;
  logic [W:0]       w_sum;
  logic [2*W-1:0]   w_mul_step, w_p_step, w_mul_res;

`ifdef MULT_DIV_DIVIDE_EN
  logic             r_is_div, r_neg_hi, r_b_zero, r_dz;
  logic [W:0]       w_rem_sh, w_diff;
  logic [2*W-1:0]   w_div_step;
  logic [W-1:0]     w_q, w_r;
  assign w_op_ok = 1'b1;
`else
  assign w_op_ok = ~op[1];
`endif

  // start is honoured only outside RUN and only for an implemented op
  assign w_accept = start && (r_state != S_RUN) && w_op_ok;
  assign w_last   = (r_cnt == C_LAST);

  // Signed ops work on magnitudes; sign is re-applied at completion
  assign w_a_neg = op[0] & operand_a[W-1];
  assign w_b_neg = op[0] & operand_b[W-1];
  assign w_a_mag = w_a_neg ? -operand_a : operand_a;
  assign w_b_mag = w_b_neg ? -operand_b : operand_b;

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole register right by one.
  assign w_sum      = {1'b0, r_p[2*W-1:W]} + (r_p[0] ? {1'b0, r_m} : {(W+1){1'b0}});
  assign w_mul_step = {w_sum, r_p[W-1:1]};
  assign w_mul_res  = r_neg_lo ? -w_p_step : w_p_step;

`ifdef MULT_DIV_DIVIDE_EN
  // Restoring step: shift next dividend bit into the remainder, try to
  // subtract the divisor, keep the difference only when it did not borrow.
  assign w_rem_sh   = r_p[2*W-1:W-1];
  assign w_diff     = w_rem_sh - {1'b0, r_m};
  assign w_div_step = w_diff[W] ? {w_rem_sh[W-1:0], r_p[W-2:0], 1'b0}
                                : {w_diff[W-1:0],   r_p[W-2:0], 1'b1};
  assign w_p_step   = r_is_div ? w_div_step : w_mul_step;
  assign w_q        = w_p_step[W-1:0];
  assign w_r        = w_p_step[2*W-1:W];
`else
  assign w_p_step   = w_mul_step;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (w_last)   w_state_next = S_DONE;
      S_DONE:  w_state_next = w_accept ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      r_m      <= '0;
      r_p      <= '0;
      r_neg_lo <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
`ifdef MULT_DIV_DIVIDE_EN
      r_is_div <= 1'b0;
      r_neg_hi <= 1'b0;
      r_b_zero <= 1'b0;
      r_dz     <= 1'b0;
`endif
    end else if (w_accept) begin
      r_cnt    <= '0;
      r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef MULT_DIV_DIVIDE_EN
      r_is_div <= op[1];
      r_neg_hi <= w_a_neg;
      r_b_zero <= (operand_b == '0);
      r_m      <= op[1] ? w_b_mag : w_a_mag;
      r_p      <= op[1] ? {{W{1'b0}}, w_a_mag} : {{W{1'b0}}, w_b_mag};
`else
      r_m      <= w_a_mag;
      r_p      <= {{W{1'b0}}, w_b_mag};
`endif
    end else if (r_state == S_RUN) begin
      r_p   <= w_p_step;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
`ifdef MULT_DIV_DIVIDE_EN
        if (r_is_div) begin
          // A zero divisor already leaves the dividend in the remainder;
          // only the quotient needs forcing to all ones.
          r_lo <= r_b_zero ? {W{1'b1}} : (r_neg_lo ? -w_q : w_q);
          r_hi <= r_neg_hi ? -w_r : w_r;
        end else begin
          r_lo <= w_mul_res[W-1:0];
          r_hi <= w_mul_res[2*W-1:W];
        end
        r_dz <= r_is_div & r_b_zero;
`else
        r_lo <= w_mul_res[W-1:0];
        r_hi <= w_mul_res[2*W-1:W];
`endif
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign hi   = r_hi;
  assign lo   = r_lo;
`ifdef MULT_DIV_DIVIDE_EN
  assign div_zero = r_dz & done;
`else
  assign div_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Directed self-checking bench for mult_div_unit (DATA_WIDTH=32).
//            Divide scenarios are selected by MULT_DIV_DIVIDE_EN; without it
//            the bench checks that divide requests are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Issue one operation from idle and return at the negedge where done is
  // seen (or after the cycle budget). cycles = busy cycles observed.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1; op = 2'b00; operand_a = 32'd0; operand_b = 32'd0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0)     begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL reset_dz got=%b want=0", div_zero); end
    total++; if (hi !== 32'h0)      begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0)      begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    reset = 1'b0;                      // start still high: accept on next edge
    @(negedge clk);
    total++; if (busy !== 1'b1)     begin bad++; $display("FAIL reset_first_accept busy got=%b want=1", busy); end
    start = 1'b0;
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_multu;
    int cyc;
    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc);
    total++; if (cyc !== 32)          begin bad++; $display("FAIL multu_busy_cycles got=%0d want=32", cyc); end
    total++; if (done !== 1'b1)       begin bad++; $display("FAIL multu_done got=%b want=1", done); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL multu_busy_at_done got=%b want=0", busy); end
    total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi got=%h want=fffffffe", hi); end
    total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo got=%h want=00000001", lo); end
    total++; if (div_zero !== 1'b0)   begin bad++; $display("FAIL multu_dz got=%b want=0", div_zero); end
    @(negedge clk);
    total++; if (done !== 1'b0)       begin bad++; $display("FAIL multu_done_pulse got=%b want=0", done); end
  endtask

  task automatic test_mult_signed;
    int cyc;
    run_op(2'b01, 32'hFFFFFFFD, 32'd7, cyc);
    total++; if (done !== 1'b1)       begin bad++; $display("FAIL mult_done got=%b want=1", done); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi got=%h want=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo got=%h want=ffffffeb", lo); end
    repeat (5) @(negedge clk);
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL hold_hi got=%h want=ffffffff", hi); end
    total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL hold_lo got=%h want=ffffffeb", lo); end
  endtask

`ifdef MULT_DIV_DIVIDE_EN
  task automatic test_divide;
    int cyc;
    run_op(2'b11, 32'hFFFFFFF9, 32'd2, cyc);
    total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo got=%h want=fffffffd", lo); end
    total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi got=%h want=ffffffff", hi); end
    run_op(2'b10, 32'd100, 32'd7, cyc);
    total++; if (lo !== 32'd14)       begin bad++; $display("FAIL divu_lo got=%0d want=14", lo); end
    total++; if (hi !== 32'd2)        begin bad++; $display("FAIL divu_hi got=%0d want=2", hi); end
    total++; if (div_zero !== 1'b0)   begin bad++; $display("FAIL divu_dz got=%b want=0", div_zero); end
    run_op(2'b11, 32'h80000000, 32'hFFFFFFFF, cyc);
    total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo got=%h want=80000000", lo); end
    total++; if (hi !== 32'h0)        begin bad++; $display("FAIL div_ovf_hi got=%h want=0", hi); end
    total++; if (div_zero !== 1'b0)   begin bad++; $display("FAIL div_ovf_dz got=%b want=0", div_zero); end
  endtask

  task automatic test_div_zero;
    int cyc;
    run_op(2'b10, 32'h1234, 32'd0, cyc);
    total++; if (cyc !== 32)          begin bad++; $display("FAIL dz_busy_cycles got=%0d want=32", cyc); end
    total++; if (done !== 1'b1)       begin bad++; $display("FAIL dz_done got=%b want=1", done); end
    total++; if (div_zero !== 1'b1)   begin bad++; $display("FAIL dz_flag got=%b want=1", div_zero); end
    total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL dz_lo got=%h want=ffffffff", lo); end
    total++; if (hi !== 32'h1234)     begin bad++; $display("FAIL dz_hi got=%h want=1234", hi); end
    @(negedge clk);
    total++; if (div_zero !== 1'b0)   begin bad++; $display("FAIL dz_pulse got=%b want=0", div_zero); end
  endtask
`else
  task automatic test_div_disabled;
    logic saw_busy, saw_done;
    logic [31:0] hi0, lo0;
    hi0 = hi; lo0 = lo;
    saw_busy = 1'b0; saw_done = 1'b0;
    @(negedge clk);
    start = 1'b1; op = 2'b10; operand_a = 32'd100; operand_b = 32'd7;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
      if (done) saw_done = 1'b1;
      if (i == 3) op = 2'b11;
    end
    start = 1'b0;
    total++; if (saw_busy !== 1'b0) begin bad++; $display("FAIL nodiv_busy got=%b want=0", saw_busy); end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL nodiv_done got=%b want=0", saw_done); end
    total++; if (hi !== hi0)        begin bad++; $display("FAIL nodiv_hi got=%h want=%h", hi, hi0); end
    total++; if (lo !== lo0)        begin bad++; $display("FAIL nodiv_lo got=%h want=%h", lo, lo0); end
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL nodiv_dz got=%b want=0", div_zero); end
  endtask
`endif

  // Operands change every cycle while start stays high; result must reflect
  // the latched 3*5. The back-to-back op that follows is aborted by reset.
  task automatic test_operand_latch_and_abort;
    logic saw_done;
    int   n;
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd5;
    @(negedge clk);
    n = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      operand_a = 32'd9 + i; operand_b = 32'd11 + i;
      @(negedge clk);
      n++;
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL latch_done got=%b want=1", done); end
    total++; if (lo !== 32'd15) begin bad++; $display("FAIL latch_lo got=%0d want=15", lo); end
    total++; if (hi !== 32'd0)  begin bad++; $display("FAIL latch_hi got=%0d want=0", hi); end
    operand_a = 32'd9; operand_b = 32'd9;
    @(negedge clk);                    // second op accepted from DONE
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_started got=%b want=1", busy); end
    repeat (9) @(negedge clk);         // 10 cycles into RUN
    reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (hi !== 32'h0)  begin bad++; $display("FAIL abort_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0)  begin bad++; $display("FAIL abort_lo got=%h want=0", lo); end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
  endtask

  task automatic test_back_to_back;
    int k;
    @(negedge clk);
    start = 1'b1; op = 2'b00; operand_a = 32'd2; operand_b = 32'd3;
    @(negedge clk);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL b2b_first_lo got=%0d want=6", lo); end
    operand_a = 32'd4; operand_b = 32'd5;   // start still high in DONE
    k = 0;
    @(negedge clk);
    k++;
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy got=%b want=1", busy); end
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      k++;
    end
    total++; if (k !== 33)      begin bad++; $display("FAIL b2b_spacing got=%0d want=33", k); end
    total++; if (lo !== 32'd20) begin bad++; $display("FAIL b2b_second_lo got=%0d want=20", lo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_signed();
`ifdef MULT_DIV_DIVIDE_EN
    test_divide();
    test_div_zero();
`else
    test_div_disabled();
`endif
    test_operand_latch_and_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
